// File: rtl/msg_bank_sequencer_pkg.sv
// Shared definitions for the message bank sequencer: default widths,
// the output buffer entry and the bank selector type.
package msg_seq_pkg;

    localparam int MSG_DATA_WIDTH = 5;
    localparam int MSG_ADDR_WIDTH = 8;

    // One RAM bank out of two.
    typedef logic bank_t;

    // Output buffer entry: message plus end-of-frame marker.
    typedef struct packed {
        logic [MSG_DATA_WIDTH-1:0] data;
        logic                      last;
    } buf_entry_t;

endpackage

// File: rtl/msg_bank_sequencer_if.sv
// Bus bundle of the message bank sequencer: input stream, output stream
// and the shared single-port RAM interface. The sequencer uses the master
// modport, the surrounding logic (source, sink, RAM) uses the slave modport.
interface msg_bank_sequencer_if
    import msg_seq_pkg::*;
#(
    parameter int DATA_WIDTH = MSG_DATA_WIDTH,
    parameter int ADDR_WIDTH = MSG_ADDR_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0] in_shift;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic                  ram_we;
    logic                  ram_cs;
    logic                  ram_rs;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport master (
        input  in_valid, in_data, in_shift, out_ready, ram_data_out,
        output in_ready, out_valid, out_data, out_last,
               ram_address, ram_data_in, ram_we, ram_cs, ram_rs
    );

    modport slave (
        output in_valid, in_data, in_shift, out_ready, ram_data_out,
        input  in_ready, out_valid, out_data, out_last,
               ram_address, ram_data_in, ram_we, ram_cs, ram_rs
    );

endinterface

// File: rtl/msg_bank_sequencer_fifo.sv
// Two-entry skid buffer between the RAM read pipeline and the output
// stream. The head entry drives the output directly, so data and the last
// flag stay stable while the consumer stalls.
module msg_skid_fifo
    import msg_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  buf_entry_t i_entry,
    input  logic       i_ready,
    output logic       o_valid,
    output buf_entry_t o_entry,
    output logic [1:0] o_count
);

    buf_entry_t r_head;
    buf_entry_t r_tail;
    logic [1:0] r_count;
    logic       w_pop;

    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_entry = r_head;
    assign o_count = r_count;

    // Entry storage and occupancy; the producer never pushes into a full buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the two entries are plain registers, so clearing them is
            // cheap and it gives out_data/out_last a defined 0 out of reset.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_entry;
                    else                 r_tail <= i_entry;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_entry;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/msg_bank_sequencer.sv
// Ping-pong sequencer in front of the two-bank message RAM. Frames are
// written into one bank while the previously completed frame is read out
// of the other; both directions share the RAM's single port, one access
// per cycle, with a turn register splitting the port under contention.
// Optional feature macro: MSG_SEQ_SHIFT_EN enables the per-frame cyclic
// read offset taken from in_shift.
// DATA_WIDTH must equal msg_seq_pkg::MSG_DATA_WIDTH (shared buffer entry).
module msg_bank_sequencer
    import msg_seq_pkg::*;
#(
    parameter int DATA_WIDTH = MSG_DATA_WIDTH,
    parameter int ADDR_WIDTH = MSG_ADDR_WIDTH,
    parameter int FRAME_LEN  = 256
)(
    input  logic                 clk,
    input  logic                 rst_n,
    msg_bank_sequencer_if.master bus
);

    localparam int                    CNT_W    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    bank_t                 r_wr_bank;
    bank_t                 r_rd_bank;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic [1:0]            r_full;
    logic                  r_wr_turn;
    logic                  r_rd_pend;
    logic                  r_rd_pend_last;

    logic                  w_write_wanted;
    logic                  w_read_wanted;
    logic                  w_in_ready;
    logic                  w_wr_hs;
    logic                  w_rd_issue;
    logic                  w_pop;
    logic [1:0]            w_fifo_count;
    logic [2:0]            w_occ;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_out_valid;
    buf_entry_t            w_out_entry;
    buf_entry_t            w_cap_entry;

`ifdef MSG_SEQ_SHIFT_EN
    localparam logic [CNT_W-1:0] FRAME_LEN_W = CNT_W'(FRAME_LEN);

    logic [ADDR_WIDTH-1:0] r_shift [2];
    logic [CNT_W-1:0]      w_sum;

    // Latch the frame's read offset on its first write; out-of-range offsets become 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift[0] <= '0;
            r_shift[1] <= '0;
        end else if (w_wr_hs && (r_wr_addr == '0)) begin
            r_shift[r_wr_bank] <= (CNT_W'(bus.in_shift) >= FRAME_LEN_W) ? '0 : bus.in_shift;
        end
    end

    // Offset read address, wrapped by a single compare-subtract.
    always_comb begin
        w_sum     = CNT_W'(r_shift[r_rd_bank]) + CNT_W'(r_rd_cnt);
        w_rd_addr = (w_sum >= FRAME_LEN_W) ? ADDR_WIDTH'(w_sum - FRAME_LEN_W)
                                           : ADDR_WIDTH'(w_sum);
    end
`else
    logic w_unused_shift;

    assign w_unused_shift = ^bus.in_shift;
    assign w_rd_addr      = r_rd_cnt;
`endif

    // Buffer room counts the read still in flight and the entry leaving this cycle.
    assign w_pop = w_out_valid && bus.out_ready;
    assign w_occ = {1'b0, w_fifo_count} + {2'b00, r_rd_pend} - {2'b00, w_pop};

    // Port arbitration; rst_n gates both grants so the RAM port idles during reset.
    always_comb begin
        // NOTE: blocking assignments in combinational logic, every output
        // given a value on every path, so no latch can be inferred.
        w_write_wanted = !r_full[r_wr_bank];
        w_read_wanted  = r_full[r_rd_bank] && (w_occ < 3'd2);
        w_in_ready     = rst_n && w_write_wanted && (!w_read_wanted || r_wr_turn);
        w_wr_hs        = w_in_ready && bus.in_valid;
        w_rd_issue     = rst_n && w_read_wanted && !w_wr_hs;
    end

    // RAM port mux: the write handshake wins, otherwise a read, otherwise idle zeros.
    always_comb begin
        bus.ram_cs      = 1'b0;
        bus.ram_we      = 1'b0;
        bus.ram_rs      = 1'b0;
        bus.ram_address = '0;
        bus.ram_data_in = '0;
        if (w_wr_hs) begin
            bus.ram_cs      = 1'b1;
            bus.ram_we      = 1'b1;
            bus.ram_rs      = r_wr_bank;
            bus.ram_address = r_wr_addr;
            bus.ram_data_in = bus.in_data;
        end else if (w_rd_issue) begin
            bus.ram_cs      = 1'b1;
            bus.ram_rs      = r_rd_bank;
            bus.ram_address = w_rd_addr;
        end
    end

    // Bank bookkeeping: counters, full flags, turn register and read pipeline tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples the pre-edge values regardless of statement order.
            r_wr_bank      <= 1'b0;
            r_rd_bank      <= 1'b0;
            r_wr_addr      <= '0;
            r_rd_cnt       <= '0;
            r_full         <= 2'b00;
            r_wr_turn      <= 1'b1;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
        end else begin
            if (w_wr_hs) begin
                if (r_wr_addr == LAST_IDX) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_addr         <= '0;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end
            if (w_rd_issue) begin
                if (r_rd_cnt == LAST_IDX) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                    r_rd_cnt          <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
            if (w_write_wanted && w_read_wanted) begin
                r_wr_turn <= ~r_wr_turn;
            end
            r_rd_pend      <= w_rd_issue;
            r_rd_pend_last <= w_rd_issue && (r_rd_cnt == LAST_IDX);
        end
    end

    assign w_rd_data   = bus.ram_data_out;
    assign w_cap_entry = '{data: w_rd_data, last: r_rd_pend_last};

    msg_skid_fifo u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_pend),
        .i_entry (w_cap_entry),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_entry (w_out_entry),
        .o_count (w_fifo_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_entry.data;
    assign bus.out_last  = w_out_entry.last;

endmodule

// File: tb/tb_msg_bank_sequencer.sv
// Directed bench for msg_bank_sequencer with FRAME_LEN=4 and a two-bank
// RAM model. Expected output streams are written out by hand per scenario.
module tb_msg_bank_sequencer;

    localparam int DW = 5;
    localparam int AW = 8;
    localparam int FL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msg_bank_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    msg_bank_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Two-bank RAM: read data appears the cycle after the read.
    logic [DW-1:0] mem [2][256];
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) mem[bus.ram_rs][bus.ram_address] <= bus.ram_data_in;
            else            bus.ram_data_out <= mem[bus.ram_rs][bus.ram_address];
        end
    end

    // Observation logs filled by the monitor.
    logic [5:0] out_log [$];
    int         wr_cyc  [$];
    int         wr_rs   [$];
    int         acc_kind [int];
    int         rd_issued, popped, max_out, first_ov, last0_cyc;
    bit         hold_pend;
    logic [5:0] hold_val;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        out_log.delete();
        wr_cyc.delete();
        wr_rs.delete();
        acc_kind.delete();
        rd_issued = 0;
        popped    = 0;
        max_out   = 0;
        first_ov  = -1;
        last0_cyc = -1;
        hold_pend = 1'b0;
    endtask

    // Monitor sampling on the falling edge.
    initial begin
        clear_logs();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (bus.ram_cs) begin
                    acc_kind[cyc] = bus.ram_we ? 1 : 2;
                    if (bus.ram_we) begin
                        wr_cyc.push_back(cyc);
                        wr_rs.push_back(int'(bus.ram_rs));
                    end else begin
                        rd_issued++;
                        if (!bus.ram_rs && bus.ram_address == 8'd3) last0_cyc = cyc;
                    end
                end
                if (hold_pend) check("stall_hold", {bus.out_last, bus.out_data}, hold_val);
                hold_pend = bus.out_valid && !bus.out_ready;
                hold_val  = {bus.out_last, bus.out_data};
                if (bus.out_valid && bus.out_ready) begin
                    out_log.push_back({bus.out_last, bus.out_data});
                    popped++;
                end
                if (bus.out_valid && first_ov < 0) first_ov = cyc;
                if (rd_issued - popped > max_out) max_out = rd_issued - popped;
            end
        end
    end

    task automatic do_reset(input bit chk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check("rst_out_valid",   bus.out_valid,   0);
            check("rst_out_last",    bus.out_last,    0);
            check("rst_out_data",    bus.out_data,    0);
            check("rst_ram_cs",      bus.ram_cs,      0);
            check("rst_ram_we",      bus.ram_we,      0);
            check("rst_ram_rs",      bus.ram_rs,      0);
            check("rst_ram_address", bus.ram_address, 0);
            check("rst_ram_data_in", bus.ram_data_in, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        if (chk) check("rst_in_ready", bus.in_ready, 1);
        clear_logs();
        @(posedge clk);
        #1;
    endtask

    // Present one message and hold it until accepted (bounded).
    task automatic send_msg(input int d, input int sh);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(d);
        bus.in_shift = AW'(sh);
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (out_log.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (out_log.size() < n) check("wait_out_timeout", out_log.size(), n);
    endtask

    // Compare one frame of output: four messages, last flag on the fourth.
    task automatic check_out(input string tag, input int base,
                             input int d0, input int d1, input int d2, input int d3);
        int exp_d [4];
        exp_d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            int unsigned act;
            act = (base + i < out_log.size()) ? int'(out_log[base + i]) : 32'h3ff;
            check(tag, act, ((i == 3) ? 32 : 0) + exp_d[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shift  = '0;
        bus.out_ready = 1'b1;

        // Reset values, then bank swap with latency.
        do_reset(1'b1);
        for (int i = 1; i <= 4; i++) send_msg(i, 0);
        wait_out(4);
        for (int i = 0; i < 4; i++) check("swap_ram_rs", (i < wr_rs.size()) ? wr_rs[i] : 9, 0);
        check_out("swap_out", 0, 1, 2, 3, 4);
        check("swap_latency", first_ov - ((wr_cyc.size() > 3) ? wr_cyc[3] : 0), 3);

        // Shift: sampled on the first write only; out-of-range offset reads as 0.
        do_reset(1'b0);
        send_msg(10, 1); send_msg(11, 2); send_msg(12, 2); send_msg(13, 2);
        send_msg(20, 6); send_msg(21, 1); send_msg(22, 1); send_msg(23, 1);
        wait_out(8);
`ifdef MSG_SEQ_SHIFT_EN
        check_out("shift_out", 0, 11, 12, 13, 10);
`else
        check_out("shift_out", 0, 10, 11, 12, 13);
`endif
        check_out("shift_range_out", 4, 20, 21, 22, 23);

        // Both banks full under output stall.
        do_reset(1'b0);
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send_msg(i, 0);
        @(negedge clk);
        check("full_in_ready_drop", bus.in_ready, 0);
        repeat (5) @(negedge clk);
        check("full_in_ready_held", bus.in_ready, 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        begin
            int k = 0;
            @(negedge clk);
            while (!bus.in_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        check("full_in_ready_rise", bus.in_ready, 1);
        check("full_rise_after_last_read", (last0_cyc >= 0) && (last0_cyc < cyc), 1);
        wait_out(8);
        check_out("full_out_f0", 0, 1, 2, 3, 4);
        check_out("full_out_f1", 4, 5, 6, 7, 8);

        // Contention: frame B streams in while frame A is read out.
        do_reset(1'b0);
        for (int i = 5; i <= 12; i++) send_msg(i, 0);
        wait_out(8);
        begin
            int t;
            t = (wr_cyc.size() > 3) ? wr_cyc[3] : 0;
            for (int c = 1; c <= 8; c++) begin
                check("contention_grant", acc_kind.exists(t + c) ? acc_kind[t + c] : 0,
                      (c % 2 == 1) ? 1 : 2);
            end
        end
        check_out("contention_out_a", 0, 5, 6, 7, 8);
        check_out("contention_out_b", 4, 9, 10, 11, 12);

        // Backpressure: out_ready toggles every other cycle while streaming.
        do_reset(1'b0);
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 21; i <= 28; i++) send_msg(i, 0);
            end
            begin
                for (int k = 0; k < 200 && out_log.size() < 8; k++) begin
                    @(posedge clk);
                    #1;
                    if (k % 2 == 1) bus.out_ready = ~bus.out_ready;
                end
            end
        join
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_out(8);
        check_out("bp_out_f0", 0, 21, 22, 23, 24);
        check_out("bp_out_f1", 4, 25, 26, 27, 28);
        check("bp_max_outstanding", max_out <= 2, 1);

        // Reset mid-frame discards the partial frame.
        do_reset(1'b0);
        send_msg(30, 0);
        send_msg(31, 0);
        do_reset(1'b1);
        for (int i = 16; i <= 19; i++) send_msg(i, 0);
        wait_out(4);
        repeat (10) @(negedge clk);
        check_out("midrst_out", 0, 16, 17, 18, 19);
        check("midrst_out_count", out_log.size(), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/msg_bank_sequencer.md
# msg_bank_sequencer

Ping-pong sequencer that sits directly upstream of the two-bank intermediate message RAM in the LDPC decoder. It accepts a stream of 5-bit messages and writes each frame into one RAM bank. It reads the previously completed frame out of the other bank, optionally cyclically shifted, as an output stream. All traffic shares the RAM's single address/enable port, so the block arbitrates one RAM access per cycle.

## Interface
- `DATA_WIDTH`, default 5: message width; matches the RAM.
- `ADDR_WIDTH`, default 8: RAM address width.
- `FRAME_LEN`, default 256: messages per frame; must satisfy 2 ≤ `FRAME_LEN` ≤ 2^`ADDR_WIDTH`.
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid` / `in_ready`, in / out, 1: input handshake.
- `in_data`, in, `DATA_WIDTH`: message to store.
- `in_shift`, in, `ADDR_WIDTH`: cyclic read offset for the frame; sampled on the frame's first write.
- `out_valid` / `out_ready`, out / in, 1: output handshake.
- `out_data`, out, `DATA_WIDTH`: message read back.
- `out_last`, out, 1: marks the final message of a frame.
- `ram_address`, out, `ADDR_WIDTH`: RAM address.
- `ram_data_in`, out, `DATA_WIDTH`: RAM write data.
- `ram_we`, out, 1: RAM write enable.
- `ram_cs`, out, 1: RAM chip select.
- `ram_rs`, out, 1: RAM bank select.
- `ram_data_out`, in, `DATA_WIDTH`: RAM read data; valid the cycle after the read is issued.

## Operation
**Bank state**
- `wr_bank` (1 bit), `wr_addr` counter, `full[1:0]` flags, per-bank latched shift `shift[b]`.
- `rd_bank` (1 bit), `rd_cnt` counter.

**Write side**
- A write is wanted when `!full[wr_bank]`.
- A handshake performs `ram_cs=1`, `ram_we=1`, `ram_rs=wr_bank`, `ram_address=wr_addr`, `ram_data_in=in_data`.
- When `wr_addr==FRAME_LEN-1`: set `full[wr_bank]`, toggle `wr_bank`, clear `wr_addr`.

**Read side**
- A read is wanted when `full[rd_bank]` and the output buffer has room, counting the in-flight read.
- A read issues `ram_cs=1`, `ram_we=0`, `ram_rs=rd_bank`, `ram_address=(shift[rd_bank]+rd_cnt) mod FRAME_LEN`.
- On the read with `rd_cnt==FRAME_LEN-1`: clear `full[rd_bank]`, toggle `rd_bank`, clear `rd_cnt`, and tag that read as last.

**Output buffer**
- 2-entry skid FIFO holds `{data,last}`.
- `ram_data_out` is captured the cycle after its read.

**Arbitration**
- At most one RAM access per cycle.
- `in_ready` must not depend combinationally on `in_valid`.
- When both sides want the port, the `wr_turn` register decides: `in_ready = write_wanted && (!read_wanted || wr_turn)`.
- `wr_turn` toggles every cycle in which both sides want the port.
- A read issues only in cycles with no write handshake.

**Boundaries**
- Both banks full: `in_ready=0`.
- Both banks empty: no reads are issued.
- A frame's write may proceed into one bank while the other bank is being read.
- `in_shift ≥ FRAME_LEN` is latched as 0.
- Reset mid-frame discards all stored data and partial frames.

## Timing
**Reset values**
- Outputs: `in_ready=1` after the reset cycle; `out_valid=0`, `out_last=0`, `out_data=0`.
- RAM port: `ram_cs=0`, `ram_we=0`, `ram_rs=0`, `ram_address=0`, `ram_data_in=0`.
- Internal: `full=00`, `wr_bank=0`, `rd_bank=0`, `wr_turn=1`.

**Latency**
- The last write handshake of a frame occurs in cycle t.
- The first read issues in cycle t+1 (bank idle).
- Data is captured at the end of t+2; `out_valid` is high in t+3.

**Throughput**
- Sustained rate is one message per cycle in aggregate across both directions.
- With both sides streaming, the port alternates, giving ½ rate each.

**Output stream**
- `out_valid` stays high until `out_ready`.
- `out_data` and `out_last` are held stable while stalled.

## Configuration
- `MSG_SEQ_SHIFT_EN` defined: read address is `(shift[b]+rd_cnt) mod FRAME_LEN`, with the wrap done by compare-subtract, no divider.
- Undefined: `in_shift` is ignored, the shift registers are removed, and read address equals `rd_cnt`.

## Structure
- A shared package `msg_seq_pkg` holds:
  - the `DATA_WIDTH` and `ADDR_WIDTH` defaults;
  - the `{data,last}` buffer-entry typedef;
  - the `bank_t` typedef.
- One sub-module, `msg_skid_fifo`: the 2-entry output buffer with valid/ready.
- Counters, arbitration and bank flags live in the top level.

## Test plan
- **Bank swap:** FRAME_LEN=4, `out_ready=1`, write 1,2,3,4 back-to-back.
  - `ram_rs` is 0 for all four writes.
  - `out_data` is 1,2,3,4 with `out_last` on 4.
  - `out_valid` first rises 3 cycles after the 4th write.
- **Shift:** shift=1 with `MSG_SEQ_SHIFT_EN` defined, write frame 10,11,12,13.
  - Output is 11,12,13,10.
  - Without the macro the output is 10,11,12,13.
- **Both banks full:** `out_ready=0`, write 8 messages.
  - `in_ready` drops after the 8th handshake.
  - It re-asserts only after frame 0's last read is issued.
- **Contention:** streaming input with `out_ready=1` during readout of the previous bank.
  - Grants alternate write/read each cycle.
  - No two accesses occur in one cycle.
  - No data is lost or reordered.
- **Backpressure:** toggle `out_ready` every other cycle.
  - `out_data` is held while stalled.
  - At most 2 reads are outstanding.
- **Reset mid-frame:** assert `rst_n=0` after 2 of 4 writes, then write 4 new messages.
  - Only the new frame appears on the output.
  - All outputs show their reset values during reset.
